// File: rtl/async_input_conditioner_pkg.sv
// Shared constants and helpers for the asynchronous input conditioner.
package async_input_conditioner_pkg;

  localparam int unsigned DEF_CHANNELS      = 8;
  localparam int unsigned DEF_SYNC_STAGES   = 3;
  localparam int unsigned DEF_FILTER_CYCLES = 4;

  // Counter must hold values 0..FILTER_CYCLES-1 with headroom for FILTER_CYCLES.
  function automatic int unsigned filt_cnt_width(input int unsigned filter_cycles);
    return $clog2(filter_cycles + 1);
  endfunction

endpackage

// File: rtl/async_input_conditioner_if.sv
// Per-channel level inputs, clears and conditioned outputs of the conditioner.
interface async_input_conditioner_if #(
  parameter int unsigned CHANNELS = 8
);
  logic [CHANNELS-1:0] async_in;
  logic [CHANNELS-1:0] sticky_clr;
  logic [CHANNELS-1:0] filt_out;
  logic [CHANNELS-1:0] rise_pulse;
  logic [CHANNELS-1:0] fall_pulse;
  logic [CHANNELS-1:0] edge_sticky;
  logic                any_edge;

  modport master (
    output async_in, sticky_clr,
    input  filt_out, rise_pulse, fall_pulse, edge_sticky, any_edge
  );

  modport slave (
    input  async_in, sticky_clr,
    output filt_out, rise_pulse, fall_pulse, edge_sticky, any_edge
  );
endinterface

// File: rtl/input_cond_chan.sv
// One conditioner channel: synchronizer chain, stability filter, edge pulses
// and sticky change flag.
module input_cond_chan
  import async_input_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned FILTER_CYCLES = DEF_FILTER_CYCLES,
  parameter logic        RESET_BIT     = 1'b0
) (
  input  logic dest_clk,
  input  logic dest_rst,
  input  logic async_bit,
  input  logic sticky_clr,
  output logic filt_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic edge_sticky
);

  localparam int unsigned     CNT_W    = filt_cnt_width(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

  logic             sync_bit;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             filt_d;
  logic             rise_d;
  logic             fall_d;
  logic             sticky_d;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d  = '0;
    filt_d = filt_out;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync_bit != filt_out) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync_bit;
        rise_d = sync_bit;
        fall_d = ~sync_bit;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // A new edge takes priority over a clear arriving on the same cycle.
    if (rise_d || fall_d) begin
      sticky_d = 1'b1;
    end else if (sticky_clr) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = edge_sticky;
    end
  end

  always_ff @(posedge dest_clk or posedge dest_rst) begin
    if (dest_rst) begin
      sync_q      <= {SYNC_STAGES{RESET_BIT}};
      cnt_q       <= '0;
      filt_out    <= RESET_BIT;
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
      edge_sticky <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], async_bit};
      cnt_q       <= cnt_d;
      filt_out    <= filt_d;
      rise_pulse  <= rise_d;
      fall_pulse  <= fall_d;
      edge_sticky <= sticky_d;
    end
  end

endmodule

// File: rtl/async_input_conditioner.sv
// Multi-channel synchronizer + debounce filter with edge pulses, sticky
// change flags and a registered any-edge summary.
module async_input_conditioner
  import async_input_conditioner_pkg::*;
#(
  parameter int unsigned         CHANNELS      = DEF_CHANNELS,
  parameter int unsigned         SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned         FILTER_CYCLES = DEF_FILTER_CYCLES,
  parameter logic [CHANNELS-1:0] RESET_VAL     = '0
) (
  input  logic                      dest_clk,
  input  logic                      dest_rst,
  async_input_conditioner_if.slave  bus
);

  logic [CHANNELS-1:0] filt_v;
  logic [CHANNELS-1:0] rise_v;
  logic [CHANNELS-1:0] fall_v;
  logic [CHANNELS-1:0] sticky_v;
  logic                any_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    input_cond_chan #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES),
      .RESET_BIT     (RESET_VAL[i])
    ) u_chan (
      .dest_clk    (dest_clk),
      .dest_rst    (dest_rst),
      .async_bit   (bus.async_in[i]),
      .sticky_clr  (bus.sticky_clr[i]),
      .filt_out    (filt_v[i]),
      .rise_pulse  (rise_v[i]),
      .fall_pulse  (fall_v[i]),
      .edge_sticky (sticky_v[i])
    );
  end

  always_ff @(posedge dest_clk or posedge dest_rst) begin
    if (dest_rst) begin
      any_q <= 1'b0;
    end else begin
      any_q <= |(rise_v | fall_v);
    end
  end

  assign bus.filt_out    = filt_v;
  assign bus.rise_pulse  = rise_v;
  assign bus.fall_pulse  = fall_v;
  assign bus.edge_sticky = sticky_v;
  assign bus.any_edge    = any_q;

endmodule

// File: tb/tb_async_input_conditioner.sv
// Bench for async_input_conditioner: directed vectors plus randomized traffic
// over four parameterizations, all scored against a history-window model.
module tb_async_input_conditioner;

  localparam int unsigned NDUT = 4;

  typedef struct {
    logic [7:0] ain;
    logic [7:0] clr;
    logic [7:0] filt;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] sticky;
    logic       any;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] ain [NDUT];
  logic [15:0] clr [NDUT];

  int unsigned tests = 0;
  int unsigned fails = 0;

  function automatic int unsigned ch_of(input int k);
    case (k) 0: return 8; 1: return 1; 2: return 16; default: return 8; endcase
  endfunction
  function automatic int unsigned ss_of(input int k);
    case (k) 0: return 3; 1: return 2; 2: return 5; default: return 3; endcase
  endfunction
  function automatic int unsigned fc_of(input int k);
    case (k) 0: return 4; 1: return 1; 2: return 7; default: return 4; endcase
  endfunction
  function automatic logic [15:0] rv_of(input int k);
    return (k == 3) ? 16'h00A5 : 16'h0000;
  endfunction
  function automatic logic [15:0] mask_of(input int k);
    return 16'((32'd1 << ch_of(k)) - 32'd1);
  endfunction

  async_input_conditioner_if #(.CHANNELS(8))  if0 ();
  async_input_conditioner_if #(.CHANNELS(1))  if1 ();
  async_input_conditioner_if #(.CHANNELS(16)) if2 ();
  async_input_conditioner_if #(.CHANNELS(8))  if3 ();

  async_input_conditioner #(.CHANNELS(8), .SYNC_STAGES(3), .FILTER_CYCLES(4), .RESET_VAL(8'h00))
    dut0 (.dest_clk(clk), .dest_rst(rst), .bus(if0));
  async_input_conditioner #(.CHANNELS(1), .SYNC_STAGES(2), .FILTER_CYCLES(1), .RESET_VAL(1'b0))
    dut1 (.dest_clk(clk), .dest_rst(rst), .bus(if1));
  async_input_conditioner #(.CHANNELS(16), .SYNC_STAGES(5), .FILTER_CYCLES(7), .RESET_VAL(16'h0000))
    dut2 (.dest_clk(clk), .dest_rst(rst), .bus(if2));
  async_input_conditioner #(.CHANNELS(8), .SYNC_STAGES(3), .FILTER_CYCLES(4), .RESET_VAL(8'hA5))
    dut3 (.dest_clk(clk), .dest_rst(rst), .bus(if3));

  assign if0.async_in   = ain[0][7:0];
  assign if0.sticky_clr = clr[0][7:0];
  assign if1.async_in   = ain[1][0:0];
  assign if1.sticky_clr = clr[1][0:0];
  assign if2.async_in   = ain[2];
  assign if2.sticky_clr = clr[2];
  assign if3.async_in   = ain[3][7:0];
  assign if3.sticky_clr = clr[3][7:0];

  logic [15:0] a_filt [NDUT];
  logic [15:0] a_rise [NDUT];
  logic [15:0] a_fall [NDUT];
  logic [15:0] a_stk  [NDUT];
  logic        a_any  [NDUT];

  assign a_filt[0] = 16'(if0.filt_out);   assign a_rise[0] = 16'(if0.rise_pulse);
  assign a_fall[0] = 16'(if0.fall_pulse); assign a_stk[0]  = 16'(if0.edge_sticky);
  assign a_any[0]  = if0.any_edge;
  assign a_filt[1] = 16'(if1.filt_out);   assign a_rise[1] = 16'(if1.rise_pulse);
  assign a_fall[1] = 16'(if1.fall_pulse); assign a_stk[1]  = 16'(if1.edge_sticky);
  assign a_any[1]  = if1.any_edge;
  assign a_filt[2] = if2.filt_out;        assign a_rise[2] = if2.rise_pulse;
  assign a_fall[2] = if2.fall_pulse;      assign a_stk[2]  = if2.edge_sticky;
  assign a_any[2]  = if2.any_edge;
  assign a_filt[3] = 16'(if3.filt_out);   assign a_rise[3] = 16'(if3.rise_pulse);
  assign a_fall[3] = 16'(if3.fall_pulse); assign a_stk[3]  = 16'(if3.edge_sticky);
  assign a_any[3]  = if3.any_edge;

  // Reference model: histories of sampled inputs and synchronized values;
  // output follows once the last FILTER_CYCLES synced values all disagree.
  logic [15:0] m_in   [NDUT][8];
  logic [15:0] m_sync [NDUT][8];
  logic [15:0] m_filt [NDUT];
  logic [15:0] m_rise [NDUT];
  logic [15:0] m_fall [NDUT];
  logic [15:0] m_stk  [NDUT];
  logic        m_any  [NDUT];

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      for (int j = 0; j < 8; j++) begin
        m_in[k][j]   = rv_of(k);
        m_sync[k][j] = rv_of(k);
      end
      m_filt[k] = rv_of(k);
      m_rise[k] = '0;
      m_fall[k] = '0;
      m_stk[k]  = '0;
      m_any[k]  = 1'b0;
    end
  endtask

  task automatic model_step(input int k);
    logic [15:0] flip;
    logic [15:0] nf;
    flip = mask_of(k);
    for (int unsigned j = 0; j < fc_of(k); j++) flip &= m_sync[k][j] ^ m_filt[k];
    nf        = m_filt[k] ^ flip;
    m_any[k]  = |(m_rise[k] | m_fall[k]);
    m_rise[k] = flip & nf;
    m_fall[k] = flip & ~nf;
    m_stk[k]  = ((m_stk[k] & ~clr[k]) | flip) & mask_of(k);
    m_filt[k] = nf;
    for (int j = 7; j > 0; j--) m_in[k][j] = m_in[k][j-1];
    m_in[k][0] = ain[k] & mask_of(k);
    for (int j = 7; j > 0; j--) m_sync[k][j] = m_sync[k][j-1];
    m_sync[k][0] = m_in[k][ss_of(k)-1];
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("d%0d filt", k),   a_filt[k], m_filt[k]);
      check($sformatf("d%0d rise", k),   a_rise[k], m_rise[k]);
      check($sformatf("d%0d fall", k),   a_fall[k], m_fall[k]);
      check($sformatf("d%0d sticky", k), a_stk[k],  m_stk[k]);
      check($sformatf("d%0d any", k),    16'(a_any[k]), 16'(m_any[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else for (int k = 0; k < NDUT; k++) model_step(k);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt [10];
    logic [15:0] seen;
    int unsigned rcnt, fcnt, lat;

    for (int k = 0; k < NDUT; k++) begin
      ain[k] = '0;
      clr[k] = '0;
    end
    ain[3] = 16'h00A5;
    model_reset();

    // Reset held: A5-reset instance shows its reset level, all flags clear.
    repeat (3) @(negedge clk);
    compare_all();
    check("rst a5 filt", a_filt[3], 16'h00A5);
    check("rst a5 sticky", a_stk[3], 16'h0000);
    rst = 1'b0;
    seen = '0;
    for (int n = 0; n < 20; n++) begin
      tick();
      seen |= a_rise[3] | a_fall[3] | 16'(a_any[3]);
    end
    check("a5 quiet after release", seen, 16'h0000);

    // Clean rise on channel 0, then sticky clear.
    for (int n = 0; n < 6; n++) vt[n] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
    vt[6] = '{8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h01, 1'b0};
    vt[7] = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 1'b1};
    vt[8] = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
    vt[9] = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
    for (int n = 0; n < 10; n++) begin
      ain[0] = 16'(vt[n].ain);
      clr[0] = 16'(vt[n].clr);
      tick();
      check($sformatf("vec%0d filt", n),   a_filt[0], 16'(vt[n].filt));
      check($sformatf("vec%0d rise", n),   a_rise[0], 16'(vt[n].rise));
      check($sformatf("vec%0d fall", n),   a_fall[0], 16'(vt[n].fall));
      check($sformatf("vec%0d sticky", n), a_stk[0],  16'(vt[n].sticky));
      check($sformatf("vec%0d any", n),    16'(a_any[0]), 16'(vt[n].any));
    end
    clr[0] = '0;

    // Glitch of 3 cycles on channel 3 is suppressed.
    ain[0][3] = 1'b1;
    repeat (3) tick();
    ain[0][3] = 1'b0;
    seen = '0;
    for (int n = 0; n < 12; n++) begin
      tick();
      seen[0] = seen[0] | a_filt[0][3] | a_rise[0][3] | a_fall[0][3];
    end
    check("glitch3 suppressed", seen, 16'h0000);

    // 4-cycle pulse passes: one rise and one fall.
    rcnt = 0;
    fcnt = 0;
    ain[0][3] = 1'b1;
    for (int n = 0; n < 24; n++) begin
      if (n == 4) ain[0][3] = 1'b0;
      tick();
      rcnt += a_rise[0][3];
      fcnt += a_fall[0][3];
    end
    check("pulse4 rise count", 16'(rcnt), 16'd1);
    check("pulse4 fall count", 16'(fcnt), 16'd1);

    // Sticky set wins over clear on the same edge.
    ain[0][2] = 1'b1;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (a_filt[0][2]) begin
        lat = n;
        break;
      end
    end
    check("ch2 rise latency", 16'(lat), 16'd7);
    clr[0][2] = 1'b1;
    tick();
    clr[0][2] = 1'b0;
    check("ch2 cleared", 16'(a_stk[0][2]), 16'd0);
    ain[0][2] = 1'b0;
    repeat (6) tick();
    clr[0][2] = 1'b1;
    tick();
    check("ch2 fall pulse", 16'(a_fall[0][2]), 16'd1);
    check("ch2 set beats clr", 16'(a_stk[0][2]), 16'd1);
    tick();
    check("ch2 clr next cycle", 16'(a_stk[0][2]), 16'd0);
    clr[0][2] = 1'b0;

    // Reset mid-count on channel 1, then full latency again.
    ain[0][1] = 1'b1;
    repeat (5) tick();
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("midrst filt d0", a_filt[0], 16'h0000);
    check("midrst filt d3", a_filt[3], 16'h00A5);
    check("midrst sticky d0", a_stk[0], 16'h0000);
    compare_all();
    tick();
    rst = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (a_filt[0][1]) begin
        lat = n;
        break;
      end
    end
    check("ch1 latency after reset", 16'(lat), 16'd7);

    // Randomized traffic across all parameterizations.
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < NDUT; k++) begin
        ain[k] = (ain[k] ^ 16'($urandom & $urandom & $urandom)) & mask_of(k);
        clr[k] = ($urandom_range(0, 7) == 0) ? (16'($urandom) & mask_of(k)) : 16'h0000;
      end
      if (n == 750) begin
        #2 rst = 1'b1;
        model_reset();
        #1 compare_all();
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
